// File: rtl/spram_bus_arbiter_if.sv
// Bus bundle between the CPU/DMA native-bus masters, the arbiter and
// the SPRAM wrapper port.
interface spram_bus_arbiter_if;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;

  logic        dma_valid;
  logic        dma_ready;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_wstrb;
  logic [31:0] dma_rdata;

  logic [3:0]  ram_wen;
  logic [21:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rdata,
    input  dma_valid, dma_addr, dma_wdata, dma_wstrb,
    output dma_ready, dma_rdata,
    output ram_wen, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rdata,
    output dma_valid, dma_addr, dma_wdata, dma_wstrb,
    input  dma_ready, dma_rdata,
    input  ram_wen, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/spram_bus_arbiter.sv
// Round-robin CPU/DMA arbiter in front of the SPRAM bank pair.
// Four-cycle access: IDLE grant, ISSUE, CAPTURE, DONE.
module spram_bus_arbiter #(
  parameter int ADDR_LSB = 2,
  parameter int WORD_AW  = 15
) (
  input logic           clk,
  input logic           resetn,
  spram_bus_arbiter_if.slave bus
);

  localparam int RAM_AW = 22;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic                gnt_dma_q, gnt_dma_d;
  logic                last_dma_q, last_dma_d;
  logic                wr_q, wr_d;
  logic [3:0]          ram_wen_q, ram_wen_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]         ram_wdata_q, ram_wdata_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic                dma_ready_q, dma_ready_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d;
  logic [31:0]         dma_rdata_q, dma_rdata_d;

  logic                any_req;
  logic                pick_dma;

  assign any_req  = bus.cpu_valid | bus.dma_valid;
  // DMA wins only alone, or on a tie when the CPU had the last grant.
  assign pick_dma = bus.dma_valid
                  & (~bus.cpu_valid | ~last_dma_q);

  always_comb begin
    state_d     = state_q;
    gnt_dma_d   = gnt_dma_q;
    last_dma_d  = last_dma_q;
    wr_d        = wr_q;
    ram_wen_d   = '0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_dma_d  = pick_dma;
          last_dma_d = pick_dma;
          state_d    = ISSUE;
          unique case (1'b1)
            pick_dma: begin
              ram_addr_d  = RAM_AW'(
                bus.dma_addr[ADDR_LSB +: WORD_AW]);
              ram_wdata_d = bus.dma_wdata;
              ram_wen_d   = bus.dma_wstrb;
              wr_d        = |bus.dma_wstrb;
            end
            default: begin
              ram_addr_d  = RAM_AW'(
                bus.cpu_addr[ADDR_LSB +: WORD_AW]);
              ram_wdata_d = bus.cpu_wdata;
              ram_wen_d   = bus.cpu_wstrb;
              wr_d        = |bus.cpu_wstrb;
            end
          endcase
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!wr_q) begin
          if (gnt_dma_q) dma_rdata_d = bus.ram_rdata;
          else           cpu_rdata_d = bus.ram_rdata;
        end
        cpu_ready_d = ~gnt_dma_q;
        dma_ready_d = gnt_dma_q;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      gnt_dma_q   <= 1'b0;
      last_dma_q  <= 1'b1;
      wr_q        <= 1'b0;
      ram_wen_q   <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_dma_q   <= gnt_dma_d;
      last_dma_q  <= last_dma_d;
      wr_q        <= wr_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.dma_ready = dma_ready_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_spram_bus_arbiter.sv
// Bench for spram_bus_arbiter: SPRAM behavioural memory plus a
// word-array reference model and round-robin grant tracking.
module tb_spram_bus_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  spram_bus_arbiter_if bus();

  spram_bus_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [31:0] spram   [0:32767];
  logic [31:0] ref_mem [0:32767];
  bit          ref_last_dma;
  int          n_vec = 0;
  int          n_err = 0;

  // Registered SPRAM: byte write enables, one-cycle read latency.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.ram_wen[b])
        spram[bus.ram_addr[14:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    bus.ram_rdata <= spram[bus.ram_addr[14:0]];
  end

  function automatic logic [14:0] word_of(input logic [31:0] a);
    return 15'((a >> 2) % 32768);
  endfunction

  task automatic access(input bit use_dma, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input bit perturb, output logic [31:0] rd);
    logic [14:0] w;
    logic [31:0] own_before, other_before;
    int lat, wen_cyc;
    bit got;
    w = word_of(addr);
    rd = '0;
    @(negedge clk);
    own_before   = use_dma ? bus.dma_rdata : bus.cpu_rdata;
    other_before = use_dma ? bus.cpu_rdata : bus.dma_rdata;
    if (use_dma) begin
      bus.dma_addr = addr; bus.dma_wdata = wdata;
      bus.dma_wstrb = wstrb; bus.dma_valid = 1'b1;
    end else begin
      bus.cpu_addr = addr; bus.cpu_wdata = wdata;
      bus.cpu_wstrb = wstrb; bus.cpu_valid = 1'b1;
    end
    got = 0; lat = 0; wen_cyc = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_vec++;
        if (bus.ram_addr !== 22'(w) || bus.ram_wdata !== wdata
            || bus.ram_wen !== wstrb) begin
          n_err++;
          $display("FAIL issue_bus: addr %h wdata %h wen %h, want %h %h %h",
                   bus.ram_addr, bus.ram_wdata, bus.ram_wen,
                   22'(w), wdata, wstrb);
        end
        if (perturb) begin
          if (use_dma) begin
            bus.dma_addr = addr ^ 32'h40; bus.dma_wdata = ~wdata;
            bus.dma_wstrb = 4'hF;
          end else begin
            bus.cpu_addr = addr ^ 32'h40; bus.cpu_wdata = ~wdata;
            bus.cpu_wstrb = 4'hF;
          end
        end
      end
      if (bus.ram_wen !== 4'h0) wen_cyc++;
      n_vec++;
      if ((use_dma ? bus.cpu_ready : bus.dma_ready) !== 1'b0) begin
        n_err++;
        $display("FAIL other_ready: cycle %0d got 1 want 0", i);
      end
      if ((use_dma ? bus.dma_ready : bus.cpu_ready) === 1'b1) begin
        got = 1; lat = i;
        rd = use_dma ? bus.dma_rdata : bus.cpu_rdata;
      end
    end
    bus.cpu_valid = 1'b0;
    bus.dma_valid = 1'b0;
    n_vec++;
    if (!got || lat != 3) begin
      n_err++;
      $display("FAIL latency: got %0d (ready seen %0d) want 3", lat, got);
    end
    n_vec++;
    if (wen_cyc != ((wstrb != 0) ? 1 : 0)) begin
      n_err++;
      $display("FAIL wen_width: got %0d cycles want %0d",
               wen_cyc, (wstrb != 0) ? 1 : 0);
    end
    n_vec++;
    if ((use_dma ? bus.cpu_rdata : bus.dma_rdata) !== other_before) begin
      n_err++;
      $display("FAIL other_rdata: got %h want %h",
               use_dma ? bus.cpu_rdata : bus.dma_rdata, other_before);
    end
    n_vec++;
    if (wstrb != 0) begin
      if (rd !== own_before) begin
        n_err++;
        $display("FAIL write_rdata: got %h want %h", rd, own_before);
      end
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
    end else if (rd !== ref_mem[w]) begin
      n_err++;
      $display("FAIL read_data: addr %h got %h want %h", addr, rd, ref_mem[w]);
    end
    ref_last_dma = use_dma;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if (bus.ram_wen !== 0 || bus.ram_addr !== 0 || bus.ram_wdata !== 0
        || bus.cpu_ready !== 0 || bus.dma_ready !== 0
        || bus.cpu_rdata !== 0 || bus.dma_rdata !== 0) begin
      n_err++;
      $display("FAIL reset_outputs: wen %h addr %h rdy %b%b want all 0",
               bus.ram_wen, bus.ram_addr, bus.cpu_ready, bus.dma_ready);
    end
    resetn = 1'b1;
    ref_last_dma = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.ram_wen !== 0 || bus.cpu_ready !== 0 || bus.dma_ready !== 0) begin
      n_err++;
      $display("FAIL idle_outputs: wen %h rdy %b%b want 0",
               bus.ram_wen, bus.cpu_ready, bus.dma_ready);
    end
  endtask

  task automatic test_single();
    logic [31:0] rd;
    access(0, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 0, rd);
    access(0, 32'h0000_0104, 32'h0, 4'h0, 0, rd);
    n_vec++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL single_read: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd;
    access(0, 32'h0001_0000, 32'h1122_3344, 4'hF, 0, rd);
    access(1, 32'h0001_0000, 32'h0000_AA00, 4'b0010, 0, rd);
    access(0, 32'h0001_0000, 32'h0, 4'h0, 0, rd);
    n_vec++;
    if (rd !== 32'h1122_AA44) begin
      n_err++;
      $display("FAIL strobe_merge: got %h want 1122aa44", rd);
    end
    access(1, 32'h0000_0000, 32'h0, 4'h0, 0, rd);
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL bank0_untouched: got %h want 0", rd);
    end
  endtask

  task automatic test_alias();
    logic [31:0] rd;
    access(1, 32'h0002_0008, 32'h5A5A_5A5A, 4'hF, 0, rd);
    access(0, 32'h0000_000B, 32'h0, 4'h0, 0, rd);
    n_vec++;
    if (rd !== 32'h5A5A_5A5A) begin
      n_err++;
      $display("FAIL alias: got %h want 5a5a5a5a", rd);
    end
  endtask

  task automatic test_ignored_change();
    logic [31:0] rd;
    access(1, 32'h0000_0400, 32'h0BAD_CAFE, 4'hF, 1, rd);
    access(0, 32'h0000_0400, 32'h0, 4'h0, 0, rd);
    n_vec++;
    if (rd !== 32'h0BAD_CAFE) begin
      n_err++;
      $display("FAIL ignored_data: got %h want 0badcafe", rd);
    end
    access(0, 32'h0000_0440, 32'h0, 4'h0, 0, rd);
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL ignored_addr: got %h want 0", rd);
    end
  endtask

  task automatic test_reset_mid_issue();
    logic [31:0] rd;
    access(0, 32'h0000_0200, 32'hCAFE_F00D, 4'hF, 0, rd);
    @(negedge clk);
    bus.cpu_addr = 32'h0000_0200; bus.cpu_wdata = 32'h1234_5678;
    bus.cpu_wstrb = 4'hF; bus.cpu_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.ram_wen !== 4'hF) begin
      n_err++;
      $display("FAIL issue_wen: got %h want f", bus.ram_wen);
    end
    #1 resetn = 1'b0;
    #1;
    n_vec++;
    if (bus.ram_wen !== 4'h0) begin
      n_err++;
      $display("FAIL async_wen_clear: got %h want 0", bus.ram_wen);
    end
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    ref_last_dma = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.cpu_ready !== 1'b0 || bus.dma_ready !== 1'b0) begin
        n_err++;
        $display("FAIL abandoned_ready: got %b%b want 00",
                 bus.cpu_ready, bus.dma_ready);
      end
    end
    access(0, 32'h0000_0200, 32'h0, 4'h0, 0, rd);
    n_vec++;
    if (rd !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL reset_no_write: got %h want cafef00d", rd);
    end
  endtask

  task automatic test_contention();
    logic [31:0] rd, cpu_prev, dma_prev, va, vb;
    bit exp_dma, who;
    int n_rdy;
    va = $urandom; vb = $urandom;
    access(0, 32'h0000_0800, va, 4'hF, 0, rd);
    access(1, 32'h0000_0804, vb, 4'hF, 0, rd);
    @(negedge clk);
    cpu_prev = bus.cpu_rdata; dma_prev = bus.dma_rdata;
    bus.cpu_addr = 32'h0000_0800; bus.cpu_wstrb = 4'h0;
    bus.dma_addr = 32'h0000_0804; bus.dma_wstrb = 4'h0;
    bus.cpu_valid = 1'b1; bus.dma_valid = 1'b1;
    exp_dma = !ref_last_dma;
    n_rdy = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bus.cpu_ready === 1'b1 || bus.dma_ready === 1'b1) begin
        n_rdy++;
        who = (bus.dma_ready === 1'b1);
        n_vec++;
        if ((bus.cpu_ready & bus.dma_ready) !== 1'b0 || who != exp_dma
            || i != 4 * n_rdy - 1) begin
          n_err++;
          $display("FAIL contention_order: cycle %0d dma %b want dma %b cycle %0d",
                   i, who, exp_dma, 4 * n_rdy - 1);
        end
        n_vec++;
        if (who) begin
          if (bus.dma_rdata !== ref_mem[word_of(32'h804)]
              || bus.cpu_rdata !== cpu_prev) begin
            n_err++;
            $display("FAIL contention_dma_data: got %h/%h want %h/%h",
                     bus.dma_rdata, bus.cpu_rdata,
                     ref_mem[word_of(32'h804)], cpu_prev);
          end
          dma_prev = bus.dma_rdata;
        end else begin
          if (bus.cpu_rdata !== ref_mem[word_of(32'h800)]
              || bus.dma_rdata !== dma_prev) begin
            n_err++;
            $display("FAIL contention_cpu_data: got %h/%h want %h/%h",
                     bus.cpu_rdata, bus.dma_rdata,
                     ref_mem[word_of(32'h800)], dma_prev);
          end
          cpu_prev = bus.cpu_rdata;
        end
        ref_last_dma = who;
        exp_dma = !who;
        if (n_rdy == 4) begin
          bus.cpu_valid = 1'b0; bus.dma_valid = 1'b0;
        end
      end
    end
    bus.cpu_valid = 1'b0; bus.dma_valid = 1'b0;
    n_vec++;
    if (n_rdy != 4) begin
      n_err++;
      $display("FAIL contention_count: got %0d want 4", n_rdy);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr;
    logic [3:0] ws;
    logic [14:0] w;
    for (int k = 0; k < 40; k++) begin
      w = 15'(16'h0300 + 16'($urandom_range(0, 7)));
      addr = ($urandom & 32'hFFFE_0000) | (32'(w) << 2)
           | 32'($urandom_range(0, 3));
      ws = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      access(bit'($urandom_range(0, 1)), addr, $urandom, ws,
             ($urandom_range(0, 3) == 0), rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      spram[i] = '0;
      ref_mem[i] = '0;
    end
    bus.cpu_valid = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_wstrb = 0;
    bus.dma_valid = 0; bus.dma_addr = 0; bus.dma_wdata = 0; bus.dma_wstrb = 0;
    ref_last_dma = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_strobe();
    test_contention();
    test_alias();
    test_ignored_change();
    test_reset_mid_issue();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spram_bus_arbiter.md
Name: spram_bus_arbiter

Overview:
- Two-master front end for the 128 KB SPRAM bank pair (2 banks x 16K x 32-bit words).
- Accepts PicoRV32 native-bus requests from the CPU and from a DMA engine, and arbitrates between them round-robin.
- Drives the SPRAM wrapper's single word-addressed port (registered wen/addr/wdata, 1-cycle read latency) and returns read data with a one-cycle ready pulse to the requesting master.

Parameters:
- ADDR_LSB, 2, byte-address bit that maps to SPRAM word address bit 0.
- WORD_AW, 15, number of word-address bits forwarded to SPRAM. Bit 14 is the bank select; the remaining upper ram_addr bits are driven 0.

Ports:
- clk  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- cpu_valid  in  1  CPU request; held until cpu_ready.
- cpu_ready  out  1  one-cycle completion pulse to CPU.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_wstrb  in  4  CPU byte strobes; 0 = read.
- cpu_rdata  out  32  CPU read data; valid while cpu_ready=1.
- dma_valid  in  1  DMA request; held until dma_ready.
- dma_ready  out  1  one-cycle completion pulse to DMA.
- dma_addr  in  32  DMA byte address.
- dma_wdata  in  32  DMA write data.
- dma_wstrb  in  4  DMA byte strobes; 0 = read.
- dma_rdata  out  32  DMA read data; valid while dma_ready=1.
- ram_wen  out  4  SPRAM byte write enables.
- ram_addr  out  22  SPRAM word address.
- ram_wdata  out  32  SPRAM write data.
- ram_rdata  in  32  SPRAM read data, valid the cycle after the address is sampled.

Behaviour:
- Reset (async, resetn=0): state=IDLE, all outputs 0, last_grant=DMA (so the CPU wins the first tie).
  - ram_wen clears immediately, without waiting for a clock edge.
  - An in-flight access is abandoned and no ready is issued.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states and transitions:
  - IDLE: if any valid is high, grant one master; register ram_addr={zeros, addr[ADDR_LSB+WORD_AW-1:ADDR_LSB]}, ram_wdata=wdata, ram_wen=wstrb; record the grant. Go to ISSUE. If no valid is high, stay in IDLE with ram_wen=0.
  - ISSUE: ram_* held stable; SPRAM samples at the end of this cycle; ram_wen returns to 0 at the end of ISSUE, so it is high for exactly one cycle. Go to CAPTURE.
  - CAPTURE: ram_addr still held, so the wrapper's bank-select read mux stays valid. For reads, the granted master's rdata register loads ram_rdata; for writes, rdata is not updated. Set the granted master's ready=1. Go to DONE.
  - DONE: ready visible to the master for this single cycle; clear ready at the end of the cycle. Go to IDLE.
- Latency: valid seen in IDLE at cycle T gives ready high during cycle T+3. Back-to-back throughput is 1 access per 4 cycles.
- A request must be seen low in the IDLE cycle after its ready, otherwise it is re-serviced. PicoRV32 and the DMA both satisfy this.
- Arbitration, evaluated only in IDLE:
  - Single requester: that requester wins.
  - Both requesting: the master that was not granted last wins; last_grant updates on every grant.
  - Strict alternation under continuous contention; neither master starves (bounded wait of one access).
- The non-granted master's ready stays 0 and its rdata is unchanged for the whole access.
- Address handling:
  - addr[1:0] is ignored.
  - addr bits at and above ADDR_LSB+WORD_AW are ignored, so accesses alias every 128 KB. Region decode is upstream.
  - ram_addr[21:WORD_AW] is always 0.
- Partial writes: wstrb is passed through unchanged; unselected bytes in SPRAM are preserved.
- Protocol violation (valid dropped before ready): the access still completes and ready still pulses. This is not an error.
- Inputs changing after grant (addr, wdata, wstrb) have no effect on the current access.

Test Plan:
- Reset: assert resetn=0 mid-ISSUE of a write with wstrb=4'hF -> ram_wen=0 within the same cycle. No cpu_ready. After release, a read of that address returns the pre-write value.
- Single write/read:
  - CPU write addr=0x0000_0104, wdata=0xDEADBEEF, wstrb=4'hF -> ram_addr=0x41 and ram_wen=4'hF for exactly 1 cycle; cpu_ready at T+3.
  - Then a CPU read of the same address -> cpu_rdata=0xDEADBEEF with cpu_ready.
- Byte strobe and bank 1:
  - Write 0x11223344 to addr 0x0001_0000 (ram_addr=0x4000, bank 1), then wstrb=4'b0010 with wdata=0x0000AA00.
  - Read -> 0x1122AA44; address 0x0000_0000 (bank 0) is unchanged.
- Contention: cpu_valid and dma_valid high continuously, both reading distinct preloaded words -> grants alternate CPU, DMA, CPU, DMA; each ready 4 cycles apart; each rdata is correct and the other master's rdata/ready are untouched.
- Aliasing: write 0x5A5A5A5A to 0x0002_0008 -> a read of 0x0000_0008 returns 0x5A5A5A5A.
- Ignored changes: change dma_wdata and dma_addr in the cycle after grant -> memory holds the originally granted data at the original address.
